// File: rtl/lm70_spi_responder_if.sv
// lm70_spi_responder_if: SPI pin bundle between an LM70 master and the responder.
//  cs_n    chip select, active-low (master -> responder)
//  sck     SPI clock, idle low (master -> responder)
//  sio_in  SIO pad input, command phase only (master -> responder)
//  sio_out SIO data to master (responder -> master)
//  sio_oe  SIO output enable, 1 = responder drives (responder -> master)
interface lm70_spi_responder_if;
  logic cs_n;
  logic sck;
  logic sio_in;
  logic sio_out;
  logic sio_oe;
  modport master (output cs_n, sck, sio_in, input sio_out, sio_oe);
  modport slave (input cs_n, sck, sio_in, output sio_out, sio_oe);
endinterface

// File: rtl/lm70_spi_responder.sv
// lm70_spi_responder: LM70-compatible SPI temperature-sensor responder, oversampling the SPI pins on clk.
//  clk, rst      system clock, asynchronous active-high reset
//  spi           SPI pins (slave modport of lm70_spi_responder_if)
//  temp_in       11-bit two's complement temperature, 0.25 C/LSB
//  temp_load     one-cycle strobe capturing temp_in
//  frame_active  high while a selected frame is in progress
//  frame_done    pulse: CS rose after >= FRAME_BITS bits
//  frame_abort   pulse: CS rose after < FRAME_BITS bits
//  shutdown      shutdown mode flag (tied 0 unless LM70_RESP_SHUTDOWN_EN is defined)
//  Define LM70_RESP_SHUTDOWN_EN to add the 8-bit command phase and shutdown mode.
module lm70_spi_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  lm70_spi_responder_if.slave        spi,
  input  logic [10:0]                temp_in,
  input  logic                       temp_load,
  output logic                       frame_active,
  output logic                       frame_done,
  output logic                       frame_abort,
  output logic                       shutdown
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);
`ifdef LM70_RESP_SHUTDOWN_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CMD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, vld_q, vld_d;
  logic cs_prev_q, sck_prev_q, armed_q, armed_d;
  logic [10:0] temp_q, temp_d;
  logic [15:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sio_out_q, sio_out_d, sio_oe_q, sio_oe_d;
  logic active_q, active_d, done_q, done_d, abort_q, abort_d;
  logic cs_s, sck_s, cs_fall, cs_rise, sck_fall;
`ifdef LM70_RESP_SHUTDOWN_EN
  logic [SYNC_STAGES-1:0] sio_sync_q, sio_sync_d;
  logic [7:0] cmd_q, cmd_d;
  logic [3:0] ccnt_q, ccnt_d;
  logic sd_q, sd_d, sck_rise;
`endif
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_fall = sck_prev_q & ~sck_s;
`ifdef LM70_RESP_SHUTDOWN_EN
  assign sck_rise = ~sck_prev_q & sck_s;
  assign shutdown = sd_q;
`else
  assign shutdown = 1'b0;
`endif
  assign spi.sio_out  = sio_out_q;
  assign spi.sio_oe   = sio_oe_q;
  assign frame_active = active_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
    vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
    temp_d     = temp_load ? temp_in : temp_q;
    // Arm only on a cs_n=1 that came from the pin, not from the synchroniser reset value.
    armed_d    = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sio_out_d  = sio_out_q;
    sio_oe_d   = sio_oe_q;
    active_d   = active_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
`ifdef LM70_RESP_SHUTDOWN_EN
    sio_sync_d = {sio_sync_q[SYNC_STAGES-2:0], spi.sio_in};
    cmd_d      = cmd_q;
    ccnt_d     = ccnt_q;
    sd_d       = sd_q;
`endif
    if (state_q == IDLE) begin
      if (armed_q && cs_fall) begin
`ifdef LM70_RESP_SHUTDOWN_EN
        shift_d = sd_q ? 16'h800F : {temp_d, 5'b11111};
`else
        shift_d = {temp_d, 5'b11111};
`endif
        sio_out_d = shift_d[15];
        cnt_d     = '0;
        sio_oe_d  = 1'b1;
        active_d  = 1'b1;
        state_d   = SHIFT;
      end
    end else if (cs_rise) begin
      // CS rise outranks a coincident SCK fall, so that bit is never counted.
      state_d   = IDLE;
      sio_oe_d  = 1'b0;
      sio_out_d = 1'b0;
      active_d  = 1'b0;
      done_d    = cnt_q == FULL;
      abort_d   = cnt_q != FULL;
`ifdef LM70_RESP_SHUTDOWN_EN
      if (state_q == CMD && ccnt_q == 4'd8 && cmd_q == 8'hFF) sd_d = 1'b1;
      if (state_q == CMD && ccnt_q == 4'd8 && cmd_q == 8'h00) sd_d = 1'b0;
`endif
    end else if (state_q == SHIFT) begin
      if (sck_fall) begin
        shift_d   = {shift_q[14:0], 1'b0};
        sio_out_d = shift_q[14];
        cnt_d     = cnt_q == FULL ? cnt_q : cnt_q + 1'b1;
`ifdef LM70_RESP_SHUTDOWN_EN
        if (cnt_q == LAST) begin
          state_d   = CMD;
          sio_oe_d  = 1'b0;
          sio_out_d = 1'b0;
          cmd_d     = '0;
          ccnt_d    = '0;
        end
`endif
      end
`ifdef LM70_RESP_SHUTDOWN_EN
    end else if (sck_rise && ccnt_q != 4'd8) begin
      // sio_in goes through the same sync depth as sck, so it is sampled just after the pin rise.
      cmd_d  = {cmd_q[6:0], sio_sync_q[SYNC_STAGES-1]};
      ccnt_d = ccnt_q + 4'd1;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      vld_q      <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      temp_q     <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      sio_out_q  <= 1'b0;
      sio_oe_q   <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
`ifdef LM70_RESP_SHUTDOWN_EN
      sio_sync_q <= '0;
      cmd_q      <= '0;
      ccnt_q     <= '0;
      sd_q       <= 1'b0;
`endif
    end else begin
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      vld_q      <= vld_d;
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      armed_q    <= armed_d;
      temp_q     <= temp_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sio_out_q  <= sio_out_d;
      sio_oe_q   <= sio_oe_d;
      active_q   <= active_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
`ifdef LM70_RESP_SHUTDOWN_EN
      sio_sync_q <= sio_sync_d;
      cmd_q      <= cmd_d;
      ccnt_q     <= ccnt_d;
      sd_q       <= sd_d;
`endif
    end
  end
endmodule

// File: tb/tb_lm70_spi_responder.sv
// tb_lm70_spi_responder: directed SPI master bench for lm70_spi_responder.
module tb_lm70_spi_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] temp_in = '0;
  logic temp_load = 1'b0;
  logic frame_active, frame_done, frame_abort, shutdown;
  int errors = 0;
  int checks = 0;
  int done_n = 0;
  int abort_n = 0;
  logic [15:0] rd;
  lm70_spi_responder_if spi ();
  lm70_spi_responder dut (
    .clk(clk), .rst(rst), .spi(spi.slave), .temp_in(temp_in), .temp_load(temp_load),
    .frame_active(frame_active), .frame_done(frame_done), .frame_abort(frame_abort), .shutdown(shutdown)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (frame_done) done_n <= done_n + 1;
    if (frame_abort) abort_n <= abort_n + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(input logic [10:0] v);
    temp_in = v;
    temp_load = 1'b1;
    wait_clk(1);
    temp_load = 1'b0;
  endtask
  task automatic sck_bit(output logic b, input logic din);
    b = spi.sio_out;
    spi.sio_in = din;
    spi.sck = 1'b1;
    wait_clk(4);
    spi.sck = 1'b0;
    wait_clk(4);
  endtask
  task automatic run_frame(input string tag, input int nbits, input int load_at, input logic [10:0] load_val,
                           input int ncmd, input logic [7:0] cmd, output logic [15:0] r,
                           output int dn, output int ab);
    logic b;
    int d0, a0;
    d0 = done_n;
    a0 = abort_n;
    r = '0;
    spi.cs_n = 1'b0;
    wait_clk(8);
    check({tag, ".active"}, {31'd0, frame_active}, 32'd1);
    check({tag, ".oe"}, {31'd0, spi.sio_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == load_at) load(load_val);
      sck_bit(b, 1'b0);
      if (i < 16) r = {r[14:0], b};
    end
    for (int i = 0; i < ncmd; i++) sck_bit(b, cmd[7-i]);
    spi.cs_n = 1'b1;
    wait_clk(8);
    check({tag, ".oe_end"}, {31'd0, spi.sio_oe}, 32'd0);
    dn = done_n - d0;
    ab = abort_n - a0;
  endtask
  initial begin
    int dn, ab;
    logic b;
    spi.cs_n = 1'b1;
    spi.sck = 1'b0;
    spi.sio_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spi.cs_n = i[0];
      spi.sck = i[1];
      wait_clk(1);
    end
    check("rst.oe", {31'd0, spi.sio_oe}, 32'd0);
    check("rst.out", {31'd0, spi.sio_out}, 32'd0);
    check("rst.pulses", {29'd0, frame_done, frame_abort, frame_active}, 32'd0);
    check("rst.shutdown", {31'd0, shutdown}, 32'd0);
    spi.cs_n = 1'b0;
    spi.sck = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(12);
    check("unarmed.oe", {31'd0, spi.sio_oe}, 32'd0);
    check("unarmed.active", {31'd0, frame_active}, 32'd0);
    spi.cs_n = 1'b1;
    wait_clk(8);
    run_frame("t1", 16, -1, '0, 0, '0, rd, dn, ab);
    check("t1.data", {16'd0, rd}, 32'h001F);
    load(11'h0C8);
    run_frame("t2", 16, -1, '0, 0, '0, rd, dn, ab);
    check("t2.data", {16'd0, rd}, 32'h191F);
    check("t2.done", dn, 1);
    check("t2.abort", ab, 0);
    run_frame("t3a", 16, 5, 11'h064, 0, '0, rd, dn, ab);
    check("t3a.data", {16'd0, rd}, 32'h191F);
    run_frame("t3b", 16, -1, '0, 0, '0, rd, dn, ab);
    check("t3b.data", {16'd0, rd}, 32'h0C9F);
    load(11'h0C8);
    run_frame("t4a", 8, -1, '0, 0, '0, rd, dn, ab);
    check("t4a.data", {24'd0, rd[7:0]}, 32'h19);
    check("t4a.abort", ab, 1);
    check("t4a.done", dn, 0);
    run_frame("t4b", 16, -1, '0, 0, '0, rd, dn, ab);
    check("t4b.data", {16'd0, rd}, 32'h191F);
    check("t4b.done", dn, 1);
    spi.cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 6; i++) sck_bit(b, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    check("t5.rst_oe", {31'd0, spi.sio_oe}, 32'd0);
    rst = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 4; i++) sck_bit(b, 1'b0);
    check("t5.held_oe", {31'd0, spi.sio_oe}, 32'd0);
    check("t5.held_active", {31'd0, frame_active}, 32'd0);
    spi.cs_n = 1'b1;
    wait_clk(8);
    load(11'h0C8);
    run_frame("t5", 16, -1, '0, 0, '0, rd, dn, ab);
    check("t5.data", {16'd0, rd}, 32'h191F);
    check("t5.done", dn, 1);
`ifdef LM70_RESP_SHUTDOWN_EN
    run_frame("t6a", 16, -1, '0, 8, 8'hFF, rd, dn, ab);
    check("t6a.data", {16'd0, rd}, 32'h191F);
    check("t6a.done", dn, 1);
    check("t6a.shutdown", {31'd0, shutdown}, 32'd1);
    run_frame("t6b", 16, -1, '0, 8, 8'h00, rd, dn, ab);
    check("t6b.data", {16'd0, rd}, 32'h800F);
    check("t6b.shutdown", {31'd0, shutdown}, 32'd0);
    run_frame("t6c", 16, -1, '0, 8, 8'hA5, rd, dn, ab);
    check("t6c.data", {16'd0, rd}, 32'h191F);
    check("t6c.shutdown", {31'd0, shutdown}, 32'd0);
    run_frame("t6d", 16, -1, '0, 7, 8'hFF, rd, dn, ab);
    check("t6d.shutdown", {31'd0, shutdown}, 32'd0);
`else
    run_frame("t6", 24, -1, '0, 0, '0, rd, dn, ab);
    check("t6.data", {16'd0, rd}, 32'h191F);
    check("t6.done", dn, 1);
    check("t6.shutdown", {31'd0, shutdown}, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
